// File: rtl/sdp_brdma_eg_ctx_reader.sv
// Egress end of the BRDMA context queue: pops one context per DMA read and tags the
// returning response beats with per-request last / layer-end flags through one output register.
`timescale 1ns/1ps
module sdp_brdma_eg_ctx_reader #(
    parameter int unsigned DW     = 512,
    parameter int unsigned BEAT_W = 12
) (
    input  logic            nvdla_core_clk_mgated,
    input  logic            nvdla_core_rstn,
    input  logic            cq2eg_pvld,
    output logic            cq2eg_prdy,
    input  logic [15:0]     cq2eg_pd,
    input  logic            dma_rd_rsp_pvld,
    output logic            dma_rd_rsp_prdy,
    input  logic [DW-1:0]   dma_rd_rsp_pd,
    output logic            eg2up_pvld,
    input  logic            eg2up_prdy,
    output logic [DW+1:0]   eg2up_pd,
    output logic            eg_busy,
    output logic            layer_done
);

    localparam int unsigned LE_BIT = 12;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t              state_q;
    logic [BEAT_W-1:0]   beat_cnt_q;
    logic [BEAT_W-1:0]   ctx_beats_m1_q;
    logic                ctx_layer_end_q;
    logic                eg2up_pvld_q;
    logic [DW+1:0]       eg2up_pd_q;
    logic                layer_done_q;

    logic                out_free;
    logic                rsp_acc;
    logic                is_last;
    logic                ctx_pop;
    logic                unused_rsvd;

    // Reserved context bits carry no meaning here.
    assign unused_rsvd = ^cq2eg_pd[15:13];

    assign out_free        = !eg2up_pvld_q || eg2up_prdy;
    assign dma_rd_rsp_prdy = (state_q == ACTIVE) && out_free;
    assign rsp_acc         = dma_rd_rsp_pvld && dma_rd_rsp_prdy;
    assign is_last         = (beat_cnt_q == ctx_beats_m1_q);
    // Pop in the same cycle as the last beat so consecutive contexts run without a bubble.
    assign cq2eg_prdy      = (state_q == IDLE) || (rsp_acc && is_last);
    assign ctx_pop         = cq2eg_pvld && cq2eg_prdy;

    always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_q         <= IDLE;
            beat_cnt_q      <= '0;
            ctx_beats_m1_q  <= '0;
            ctx_layer_end_q <= 1'b0;
            eg2up_pvld_q    <= 1'b0;
            eg2up_pd_q      <= '0;
            layer_done_q    <= 1'b0;
        end else begin
            layer_done_q <= eg2up_pvld_q && eg2up_prdy && eg2up_pd_q[DW+1];

            // Accepted beat carries the flags of the context it was counted against.
            if (rsp_acc) begin
                eg2up_pvld_q <= 1'b1;
                eg2up_pd_q   <= {ctx_layer_end_q & is_last, is_last, dma_rd_rsp_pd};
            end else if (eg2up_prdy) begin
                eg2up_pvld_q <= 1'b0;
            end

            if (ctx_pop) begin
                state_q         <= ACTIVE;
                beat_cnt_q      <= '0;
                ctx_beats_m1_q  <= cq2eg_pd[BEAT_W-1:0];
                ctx_layer_end_q <= cq2eg_pd[LE_BIT];
            end else if (rsp_acc) begin
                if (is_last) begin
                    state_q    <= IDLE;
                    beat_cnt_q <= '0;
                end else begin
                    beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
                end
            end
        end
    end

    assign eg2up_pvld = eg2up_pvld_q;
    assign eg2up_pd   = eg2up_pd_q;
    assign layer_done = layer_done_q;
    assign eg_busy    = (state_q == ACTIVE) || eg2up_pvld_q;

endmodule

// File: tb/tb_sdp_brdma_eg_ctx_reader.sv
// Scoreboard bench for sdp_brdma_eg_ctx_reader: queue-fed context/beat drivers, expected
// output beats pushed at stimulus time and popped by a negedge monitor on each handoff.
`timescale 1ns/1ps
module tb_sdp_brdma_eg_ctx_reader;

    localparam int unsigned DW = 512;

    logic              clk;
    logic              rstn;
    logic              cq2eg_pvld;
    logic              cq2eg_prdy;
    logic [15:0]       cq2eg_pd;
    logic              dma_rd_rsp_pvld;
    logic              dma_rd_rsp_prdy;
    logic [DW-1:0]     dma_rd_rsp_pd;
    logic              eg2up_pvld;
    logic              eg2up_prdy;
    logic [DW+1:0]     eg2up_pd;
    logic              eg_busy;
    logic              layer_done;

    sdp_brdma_eg_ctx_reader #(.DW(DW), .BEAT_W(12)) dut (
        .nvdla_core_clk_mgated (clk),
        .nvdla_core_rstn       (rstn),
        .cq2eg_pvld            (cq2eg_pvld),
        .cq2eg_prdy            (cq2eg_prdy),
        .cq2eg_pd              (cq2eg_pd),
        .dma_rd_rsp_pvld       (dma_rd_rsp_pvld),
        .dma_rd_rsp_prdy       (dma_rd_rsp_prdy),
        .dma_rd_rsp_pd         (dma_rd_rsp_pd),
        .eg2up_pvld            (eg2up_pvld),
        .eg2up_prdy            (eg2up_prdy),
        .eg2up_pd              (eg2up_pd),
        .eg_busy               (eg_busy),
        .layer_done            (layer_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0]   ctx_q[$];
    logic [DW-1:0] beat_q[$];
    logic [DW+1:0] exp_q[$];
    int            fire_log[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int hs_cnt = 0;
    int ld_cnt = 0;
    int tag    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] mk(input int unsigned n);
        logic [DW-1:0] d;
        for (int k = 0; k < int'(DW / 32); k++)
            d[k*32 +: 32] = n * 32'h9E37_79B1 + 32'(k);
        return d;
    endfunction

    task automatic chk(input string name, input logic [DW+1:0] act, input logic [DW+1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Queue a context and its beats; expected outputs follow directly from beats_m1/layer_end.
    task automatic push_ctx(input int unsigned bm1, input logic le, input logic [2:0] rsvd);
        logic [DW-1:0] d;
        logic          last;
        ctx_q.push_back({rsvd, le, 12'(bm1)});
        for (int unsigned i = 0; i <= bm1; i++) begin
            d    = mk(32'(tag));
            tag++;
            last = (i == bm1);
            beat_q.push_back(d);
            exp_q.push_back({le & last, last, d});
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || beat_q.size() != 0 || eg2up_pvld) && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Drivers: present queue heads, pop on the handshake seen before each edge.
    initial begin
        logic cqf, df;
        cq2eg_pvld      = 1'b0;
        cq2eg_pd        = '0;
        dma_rd_rsp_pvld = 1'b0;
        dma_rd_rsp_pd   = '0;
        forever begin
            @(negedge clk);
            cqf = cq2eg_pvld && cq2eg_prdy;
            df  = dma_rd_rsp_pvld && dma_rd_rsp_prdy;
            @(posedge clk);
            #1;
            if (cqf && ctx_q.size() != 0) void'(ctx_q.pop_front());
            if (df && beat_q.size() != 0) void'(beat_q.pop_front());
            cq2eg_pvld      = (ctx_q.size() != 0);
            cq2eg_pd        = (ctx_q.size() != 0) ? ctx_q[0] : 16'h0;
            dma_rd_rsp_pvld = (beat_q.size() != 0);
            dma_rd_rsp_pd   = (beat_q.size() != 0) ? beat_q[0] : '0;
        end
    end

    // Monitor: scoreboard on each handoff, plus valid-latency and layer_done models.
    logic m_pvld = 1'b0;
    logic exp_ld = 1'b0;
    always @(negedge clk) begin
        logic [DW+1:0] e;
        logic          nxt_ld;
        if (!rstn) begin
            m_pvld = 1'b0;
            exp_ld = 1'b0;
        end else begin
            chk("eg2up_pvld_model", (DW+2)'(eg2up_pvld), (DW+2)'(m_pvld));
            chk("layer_done_model", (DW+2)'(layer_done), (DW+2)'(exp_ld));
            if (layer_done) ld_cnt++;
            nxt_ld = 1'b0;
            if (eg2up_pvld && eg2up_prdy) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", eg2up_pd);
                end else begin
                    e = exp_q.pop_front();
                    chk("eg2up_pd", eg2up_pd, e);
                    nxt_ld = e[DW+1];
                end
            end
            if (dma_rd_rsp_pvld && dma_rd_rsp_prdy) begin
                fire_log.push_back(cyc);
                m_pvld = 1'b1;
            end else if (eg2up_prdy) begin
                m_pvld = 1'b0;
            end
            exp_ld = nxt_ld;
        end
    end

    initial begin
        int ld0, hs0, n;
        logic [DW+1:0] held;
        rstn       = 1'b0;
        eg2up_prdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cq2eg_prdy", (DW+2)'(cq2eg_prdy), (DW+2)'(1));
        chk("rst_dma_prdy",   (DW+2)'(dma_rd_rsp_prdy), (DW+2)'(0));
        chk("rst_eg2up_pvld", (DW+2)'(eg2up_pvld), (DW+2)'(0));
        chk("rst_eg2up_pd",   eg2up_pd, '0);
        chk("rst_layer_done", (DW+2)'(layer_done), (DW+2)'(0));
        chk("rst_eg_busy",    (DW+2)'(eg_busy), (DW+2)'(0));
        #1 rstn = 1'b1;

        // Beat offered with no context is held off, then delivered once a context arrives.
        beat_q.push_back(mk(32'hBEEF));
        exp_q.push_back({1'b0, 1'b1, mk(32'hBEEF)});
        repeat (10) begin
            @(negedge clk);
            chk("idle_dma_prdy", (DW+2)'(dma_rd_rsp_prdy), (DW+2)'(0));
            chk("idle_eg2up_pvld", (DW+2)'(eg2up_pvld), (DW+2)'(0));
        end
        @(posedge clk);
        #1;
        ctx_q.push_back(16'h0000);
        wait_drain(50);

        // Four-beat context, no layer end.
        ld0 = ld_cnt;
        push_ctx(3, 1'b0, 3'b000);
        wait_drain(50);
        chk("t2_no_layer_done", (DW+2)'(ld_cnt - ld0), (DW+2)'(0));
        chk("t2_idle_busy", (DW+2)'(eg_busy), (DW+2)'(0));
        chk("t2_idle_cq_prdy", (DW+2)'(cq2eg_prdy), (DW+2)'(1));

        // Back-to-back contexts, reserved bits set, no bubble between them.
        ld0 = ld_cnt;
        fire_log.delete();
        push_ctx(1, 1'b0, 3'b111);
        push_ctx(0, 1'b1, 3'b101);
        wait_drain(50);
        chk("t3_fire_count", (DW+2)'(fire_log.size()), (DW+2)'(3));
        if (fire_log.size() == 3)
            chk("t3_no_bubble", (DW+2)'(fire_log[2] - fire_log[0]), (DW+2)'(2));
        chk("t3_layer_done_once", (DW+2)'(ld_cnt - ld0), (DW+2)'(1));

        // Maximum-length context.
        ld0 = ld_cnt;
        fire_log.delete();
        push_ctx(4095, 1'b1, 3'b000);
        wait_drain(6000);
        chk("t4_beats", (DW+2)'(fire_log.size()), (DW+2)'(4096));
        chk("t4_layer_done_once", (DW+2)'(ld_cnt - ld0), (DW+2)'(1));

        // Downstream stall mid-context.
        hs0 = hs_cnt;
        push_ctx(7, 1'b0, 3'b000);
        n = 0;
        while (hs_cnt < hs0 + 2 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t5_reach_stall", (DW+2)'(n < 100), (DW+2)'(1));
        eg2up_prdy = 1'b0;
        @(negedge clk);
        held = eg2up_pd;
        chk("t5_pvld_held", (DW+2)'(eg2up_pvld), (DW+2)'(1));
        repeat (5) begin
            @(negedge clk);
            chk("t5_dma_prdy", (DW+2)'(dma_rd_rsp_prdy), (DW+2)'(0));
            chk("t5_pd_stable", eg2up_pd, held);
            chk("t5_busy", (DW+2)'(eg_busy), (DW+2)'(1));
        end
        @(posedge clk);
        #1;
        eg2up_prdy = 1'b1;
        wait_drain(100);

        // Reset while ACTIVE with a pending output beat.
        eg2up_prdy = 1'b0;
        push_ctx(3, 1'b0, 3'b000);
        n = 0;
        while (!eg2up_pvld && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_pending", (DW+2)'(eg2up_pvld), (DW+2)'(1));
        @(posedge clk);
        #2;
        rstn = 1'b0;
        ctx_q.delete();
        beat_q.delete();
        exp_q.delete();
        cq2eg_pvld      = 1'b0;
        dma_rd_rsp_pvld = 1'b0;
        @(negedge clk);
        chk("t6_rst_pvld", (DW+2)'(eg2up_pvld), (DW+2)'(0));
        chk("t6_rst_pd", eg2up_pd, '0);
        chk("t6_rst_busy", (DW+2)'(eg_busy), (DW+2)'(0));
        chk("t6_rst_cq_prdy", (DW+2)'(cq2eg_prdy), (DW+2)'(1));
        chk("t6_rst_dma_prdy", (DW+2)'(dma_rd_rsp_prdy), (DW+2)'(0));
        chk("t6_rst_layer_done", (DW+2)'(layer_done), (DW+2)'(0));
        @(posedge clk);
        #2;
        rstn       = 1'b1;
        eg2up_prdy = 1'b1;
        ld0 = ld_cnt;
        push_ctx(2, 1'b1, 3'b010);
        wait_drain(50);
        chk("t6_post_layer_done", (DW+2)'(ld_cnt - ld0), (DW+2)'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
